vx_int_unit_seq: RTL and testbench
==================================

Name: vx_int_unit_seq

Overview:
- Next-generation integer ALU/branch unit for the ALU block.
- Accepts a NUM_LANES-wide warp instruction and computes results on an ALU_LANES-wide datapath, emitting ceil-free NUM_PKTS = NUM_LANES/ALU_LANES packets with sop/eop and pid.
- Skips packets whose tmask slice is empty.
- Resolves branches/jumps from lane tid and reports them on the branch-control port after the eop handshake.

Parameters:
- NUM_LANES, 4, warp lanes per instruction; power of 2.
- ALU_LANES, 2, lanes computed per cycle; power of 2, divides NUM_LANES.
- XLEN, 32, datapath width.
- NW_WIDTH, 2, warp-id width.
- NR_BITS, 5, register-index width.
- Derived: NUM_PKTS = NUM_LANES/ALU_LANES; PID_W = max(1, clog2(NUM_PKTS)); TID_W = max(1, clog2(NUM_LANES)).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction valid
- in_ready  out  1  instruction accepted when in_valid & in_ready
- in_op  in  4  0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 AND, 5 OR, 6 XOR, 7 SLL, 8 SRL, 9 SRA, 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU
- in_is_jmp  in  1  JAL/JALR: always taken
- in_use_PC, in_use_imm  in  1 each  operand-1 = PC; operand-2 = imm (ALU ops only)
- in_wid, in_rd, in_wb  in  NW_WIDTH, NR_BITS, 1  tags
- in_tmask  in  NUM_LANES  active lanes
- in_tid  in  TID_W  branch lane
- in_PC, in_imm  in  XLEN each
- in_rs1, in_rs2  in  NUM_LANES*XLEN
- out_valid  out  1
- out_ready  in  1
- out_data  out  ALU_LANES*XLEN
- out_tmask  out  ALU_LANES
- out_pid  out  PID_W
- out_sop, out_eop  out  1 each
- out_wid, out_rd, out_wb, out_PC  out  tags copied from the instruction
- branch_valid  out  1  one-cycle pulse
- branch_wid  out  NW_WIDTH
- branch_taken  out  1
- branch_dest  out  XLEN

Behaviour:
- Reset (reset=0, async): state IDLE; out_valid, branch_valid, branch_taken = 0; all other registered outputs = 0. in_ready rises once reset is released. Any in-flight instruction is discarded; no branch is reported for it.
- States:
  - IDLE: in_ready=1. An accepted instruction is captured (operands, tags, tmask) and the unit moves to EMIT. Its first packet is presented registered, so out_valid=1 on the cycle after acceptance (latency 1).
  - EMIT: presents packet p.
    - Packet p on out_ready=1:
      - p not last emitted → advance to the next packet with non-zero tmask slice.
      - p last emitted → in_ready=1 this cycle; a same-cycle accept loads the next instruction back-to-back with no bubble, otherwise go to IDLE.
    - out_ready=0 holds every out_* stable (valid/data must not change while stalled).
- Packet contents: lanes p*ALU_LANES .. p*ALU_LANES+ALU_LANES-1; out_pid=p.
  - out_sop=1 on the first emitted packet; out_eop=1 on the last emitted packet.
  - Packets with an all-zero tmask slice are skipped.
  - If in_tmask==0, emit packet 0 only, with sop=eop=1 and out_tmask=0.
- Arithmetic, modulo 2^XLEN:
  - Operand A = in_use_PC ? PC : rs1.
  - Operand B = (in_use_imm and op<10) ? imm : rs2.
  - SLT/SLTU return 0/1.
  - Shift amount = B[clog2(XLEN)-1:0]; SRA sign-fills.
- Branch ops (10–15) and in_is_jmp:
  - Per-lane out_data = PC+4.
  - Compares use rs1 vs rs2, signed for BLT/BGE, unsigned otherwise.
- Branch resolution:
  - Computed from lane in_tid at capture.
  - taken = in_is_jmp | compare result.
  - dest = in_is_jmp ? (A[tid]+imm) & ~1 : PC+imm.
  - Registered; branch_valid pulses for exactly one cycle, on the cycle after the eop handshake, with branch_wid=wid.
  - Non-branch ops never raise branch_valid.
- A captured instruction is never altered by in_* changes while in EMIT.

Test Plan:
- NUM_LANES=4, ALU_LANES=2, ADD, rs1={1,2,3,4}, rs2={10,20,30,40}, tmask=1111, out_ready=1 → two packets on consecutive cycles:
  - data {11,22}, pid0, sop=1;
  - data {33,44}, pid1, eop=1;
  - then in_ready=1.
- Same with tmask=1100 → single packet pid1, data {33,44}, sop=eop=1; tmask=0000 → single packet pid0, sop=eop=1, tmask=00.
- SRA, rs1=0x80000000, imm=4, in_use_imm → 0xF8000000; SLTU 1 vs 0xFFFFFFFF → 1; SLT → 0.
- BLT, tid=3, rs1[3]=-5, rs2[3]=2, PC=0x1000, imm=0x40 → branch_valid one cycle after eop handshake, taken=1, dest=0x1040, out_data=0x1004 in active lanes. BGEU with the same operands → taken=1.
- JALR (in_is_jmp), rs1[0]=0x2003, imm=4 → dest=0x2006, taken=1. Hold out_ready=0 for 3 cycles during the second packet → outputs stable; branch_valid only after release.
- Back-to-back: second instruction presented during the last-packet handshake → accepted the same cycle, no bubble. Assert reset mid-EMIT → out_valid and branch_valid drop immediately; no branch is reported.

Source files
------------

// File: rtl/vx_int_unit_seq.sv
// Integer ALU/branch unit: captures a NUM_LANES warp instruction and streams it
// out as ALU_LANES-wide packets, skipping empty ones; branches resolve after eop.

module vx_int_lane #(
  parameter int XLEN = 32
) (
  input  logic [3:0]      op,
  input  logic            is_br,
  input  logic            use_pc,
  input  logic            use_imm,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] res
);
  localparam int SH_W = $clog2(XLEN);

  logic [XLEN-1:0] a, b;
  logic [SH_W-1:0] sh;

  always_comb begin
    a  = use_pc ? pc : rs1;
    b  = (use_imm && op < 4'd10) ? imm : rs2;
    sh = b[SH_W-1:0];
    case (op)
      4'd0:    res = a + b;
      4'd1:    res = a - b;
      4'd2:    res = XLEN'($signed(a) < $signed(b));
      4'd3:    res = XLEN'(a < b);
      4'd4:    res = a & b;
      4'd5:    res = a | b;
      4'd6:    res = a ^ b;
      4'd7:    res = a << sh;
      4'd8:    res = a >> sh;
      4'd9:    res = XLEN'($signed(a) >>> sh);
      default: res = '0;
    endcase
    // branches and jumps write back the link address
    if (is_br) res = pc + XLEN'(4);
  end
endmodule

module vx_int_unit_seq #(
  parameter int NUM_LANES = 4,
  parameter int ALU_LANES = 2,
  parameter int XLEN      = 32,
  parameter int NW_WIDTH  = 2,
  parameter int NR_BITS   = 5,
  localparam int NUM_PKTS = NUM_LANES / ALU_LANES,
  localparam int PID_W    = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1,
  localparam int TID_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [3:0]                in_op,
  input  logic                      in_is_jmp,
  input  logic                      in_use_PC,
  input  logic                      in_use_imm,
  input  logic [NW_WIDTH-1:0]       in_wid,
  input  logic [NR_BITS-1:0]        in_rd,
  input  logic                      in_wb,
  input  logic [NUM_LANES-1:0]      in_tmask,
  input  logic [TID_W-1:0]          in_tid,
  input  logic [XLEN-1:0]           in_PC,
  input  logic [XLEN-1:0]           in_imm,
  input  logic [NUM_LANES*XLEN-1:0] in_rs1,
  input  logic [NUM_LANES*XLEN-1:0] in_rs2,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ALU_LANES*XLEN-1:0] out_data,
  output logic [ALU_LANES-1:0]      out_tmask,
  output logic [PID_W-1:0]          out_pid,
  output logic                      out_sop,
  output logic                      out_eop,
  output logic [NW_WIDTH-1:0]       out_wid,
  output logic [NR_BITS-1:0]        out_rd,
  output logic                      out_wb,
  output logic [XLEN-1:0]           out_PC,
  output logic                      branch_valid,
  output logic [NW_WIDTH-1:0]       branch_wid,
  output logic                      branch_taken,
  output logic [XLEN-1:0]           branch_dest
);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state, state_nxt;

  logic [NUM_LANES-1:0][XLEN-1:0] lane_res;
  logic [NUM_LANES*XLEN-1:0]      res_q;
  logic [NUM_LANES-1:0]           tmask_q;
  logic [NUM_PKTS-1:0]            nz_in, nz_q;
  logic [PID_W-1:0]               pid_q, first_pid, next_pid;
  logic                           sop_q, has_next, eop;
  logic [NW_WIDTH-1:0]            wid_q;
  logic [NR_BITS-1:0]             rd_q;
  logic                           wb_q;
  logic [XLEN-1:0]                pc_q;
  logic                           br_q, br_taken_q, is_br_in, br_taken_in, cmp;
  logic [XLEN-1:0]                br_dest_q, br_dest_in, rs1_t, rs2_t, a_t;
  logic                           ready_st, accept, fire;

  assign is_br_in = in_is_jmp | (in_op >= 4'd10);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    vx_int_lane #(.XLEN(XLEN)) u_lane (
      .op     (in_op),
      .is_br  (is_br_in),
      .use_pc (in_use_PC),
      .use_imm(in_use_imm),
      .pc     (in_PC),
      .imm    (in_imm),
      .rs1    (in_rs1[l*XLEN +: XLEN]),
      .rs2    (in_rs2[l*XLEN +: XLEN]),
      .res    (lane_res[l])
    );
  end

  for (genvar g = 0; g < NUM_PKTS; g++) begin : g_nz
    assign nz_in[g] = |in_tmask[g*ALU_LANES +: ALU_LANES];
    assign nz_q[g]  = |tmask_q[g*ALU_LANES +: ALU_LANES];
  end

  // an all-zero mask still emits packet 0, so first_pid defaults to 0
  always_comb begin
    first_pid = '0;
    for (int p = NUM_PKTS-1; p >= 0; p--)
      if (nz_in[p]) first_pid = PID_W'(p);
    next_pid = pid_q;
    has_next = 1'b0;
    for (int p = NUM_PKTS-1; p >= 0; p--)
      if (nz_q[p] && p > int'(pid_q)) begin
        next_pid = PID_W'(p);
        has_next = 1'b1;
      end
  end
  assign eop = ~has_next;

  always_comb begin
    rs1_t = in_rs1[int'(in_tid)*XLEN +: XLEN];
    rs2_t = in_rs2[int'(in_tid)*XLEN +: XLEN];
    a_t   = in_use_PC ? in_PC : rs1_t;
    case (in_op)
      4'd10:   cmp = (rs1_t == rs2_t);
      4'd11:   cmp = (rs1_t != rs2_t);
      4'd12:   cmp = ($signed(rs1_t) <  $signed(rs2_t));
      4'd13:   cmp = ($signed(rs1_t) >= $signed(rs2_t));
      4'd14:   cmp = (rs1_t <  rs2_t);
      4'd15:   cmp = (rs1_t >= rs2_t);
      default: cmp = 1'b0;
    endcase
    br_taken_in = in_is_jmp | cmp;
    br_dest_in  = in_is_jmp ? ((a_t + in_imm) & ~XLEN'(1)) : (in_PC + in_imm);
  end

  assign out_valid = (state == EMIT);
  assign fire      = out_valid & out_ready;
  assign in_ready  = ready_st & reset;
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_nxt = state;
    ready_st  = 1'b0;
    case (state)
      IDLE: begin
        ready_st = 1'b1;
        if (accept) state_nxt = EMIT;
      end
      EMIT: if (out_ready && eop) begin
        ready_st  = 1'b1;
        state_nxt = accept ? EMIT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_q        <= '0;
      tmask_q      <= '0;
      pid_q        <= '0;
      sop_q        <= 1'b0;
      wid_q        <= '0;
      rd_q         <= '0;
      wb_q         <= 1'b0;
      pc_q         <= '0;
      br_q         <= 1'b0;
      br_taken_q   <= 1'b0;
      br_dest_q    <= '0;
      branch_valid <= 1'b0;
      branch_taken <= 1'b0;
      branch_dest  <= '0;
      branch_wid   <= '0;
    end else begin
      if (accept) begin
        res_q      <= lane_res;
        tmask_q    <= in_tmask;
        pid_q      <= first_pid;
        sop_q      <= 1'b1;
        wid_q      <= in_wid;
        rd_q       <= in_rd;
        wb_q       <= in_wb;
        pc_q       <= in_PC;
        br_q       <= is_br_in;
        br_taken_q <= br_taken_in;
        br_dest_q  <= br_dest_in;
      end else if (fire && !eop) begin
        pid_q <= next_pid;
        sop_q <= 1'b0;
      end
      // report uses the retiring instruction's state, even when a new one loads
      branch_valid <= fire & eop & br_q;
      if (fire && eop && br_q) begin
        branch_taken <= br_taken_q;
        branch_dest  <= br_dest_q;
        branch_wid   <= wid_q;
      end
    end
  end

  assign out_data  = res_q[int'(pid_q)*ALU_LANES*XLEN +: ALU_LANES*XLEN];
  assign out_tmask = tmask_q[int'(pid_q)*ALU_LANES +: ALU_LANES];
  assign out_pid   = pid_q;
  assign out_sop   = sop_q;
  assign out_eop   = eop & out_valid;
  assign out_wid   = wid_q;
  assign out_rd    = rd_q;
  assign out_wb    = wb_q;
  assign out_PC    = pc_q;
endmodule

// File: tb/tb_vx_int_unit_seq.sv
// Scoreboard bench for vx_int_unit_seq: expected packets/branches are queued
// at acceptance and compared as the unit emits them.

module tb_vx_int_unit_seq;
  localparam int NL = 4, AL = 2, XL = 32;

  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;

  logic                 in_valid = 0, in_ready;
  logic [3:0]           in_op = 0;
  logic                 in_is_jmp = 0, in_use_PC = 0, in_use_imm = 0;
  logic [1:0]           in_wid = 0;
  logic [4:0]           in_rd = 0;
  logic                 in_wb = 0;
  logic [NL-1:0]        in_tmask = 0;
  logic [1:0]           in_tid = 0;
  logic [XL-1:0]        in_PC = 0, in_imm = 0;
  logic [NL-1:0][XL-1:0] in_rs1 = '0, in_rs2 = '0;
  logic                 out_valid, out_ready = 1;
  logic [AL*XL-1:0]     out_data;
  logic [AL-1:0]        out_tmask;
  logic                 out_pid, out_sop, out_eop;
  logic [1:0]           out_wid;
  logic [4:0]           out_rd;
  logic                 out_wb;
  logic [XL-1:0]        out_PC;
  logic                 branch_valid, branch_taken;
  logic [1:0]           branch_wid;
  logic [XL-1:0]        branch_dest;

  vx_int_unit_seq #(.NUM_LANES(NL), .ALU_LANES(AL), .XLEN(XL), .NW_WIDTH(2), .NR_BITS(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_is_jmp(in_is_jmp), .in_use_PC(in_use_PC), .in_use_imm(in_use_imm), .in_wid(in_wid),
    .in_rd(in_rd), .in_wb(in_wb), .in_tmask(in_tmask), .in_tid(in_tid), .in_PC(in_PC),
    .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_tmask(out_tmask), .out_pid(out_pid),
    .out_sop(out_sop), .out_eop(out_eop), .out_wid(out_wid), .out_rd(out_rd), .out_wb(out_wb),
    .out_PC(out_PC), .branch_valid(branch_valid), .branch_wid(branch_wid),
    .branch_taken(branch_taken), .branch_dest(branch_dest)
  );

  typedef struct packed {
    logic [3:0] op; logic jmp, upc, uimm; logic [1:0] wid; logic [4:0] rd; logic wb;
    logic [3:0] tmask; logic [1:0] tid; logic [31:0] pc, imm; logic [3:0][31:0] rs1, rs2;
  } ins_t;

  typedef struct packed {
    logic [63:0] data; logic [1:0] tmask; logic pid, sop, eop, br, taken;
    logic [31:0] dest; logic [1:0] wid; logic [4:0] rd; logic wb; logic [31:0] pc;
  } pkt_t;

  pkt_t sb[$];
  int n_chk = 0, n_err = 0, cyc = 0, gap = 0, last_eop_cyc = 0;
  bit br_due = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3: return (a < b) ? 32'd1 : 32'd0;
      4: return a & b;
      5: return a | b;
      6: return a ^ b;
      7: return a << b[4:0];
      8: return a >> b[4:0];
      9: return 32'($signed(a) >>> b[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  function automatic void push_exp(input ins_t t);
    logic [3:0][31:0] r;
    logic [31:0] a, b, r1, r2;
    bit br, cmpr, first;
    int last;
    pkt_t e;
    br = t.jmp || (t.op >= 10);
    for (int l = 0; l < NL; l++) begin
      a = t.upc ? t.pc : t.rs1[l];
      b = (t.uimm && t.op < 10) ? t.imm : t.rs2[l];
      r[l] = br ? t.pc + 32'd4 : alu(t.op, a, b);
    end
    r1 = t.rs1[t.tid];
    r2 = t.rs2[t.tid];
    case (t.op)
      10: cmpr = (r1 == r2);
      11: cmpr = (r1 != r2);
      12: cmpr = $signed(r1) < $signed(r2);
      13: cmpr = !($signed(r1) < $signed(r2));
      14: cmpr = r1 < r2;
      15: cmpr = !(r1 < r2);
      default: cmpr = 0;
    endcase
    last = 0;
    for (int p = 0; p < NL/AL; p++) if (t.tmask[2*p +: 2] != 0) last = p;
    first = 1;
    for (int p = 0; p < NL/AL; p++) begin
      if (t.tmask[2*p +: 2] != 0 || (t.tmask == 0 && p == 0)) begin
        e = '0;
        e.data  = {r[2*p+1], r[2*p]};
        e.tmask = t.tmask[2*p +: 2];
        e.pid   = p[0];
        e.sop   = first;
        e.eop   = (p == last);
        e.br    = br;
        e.taken = t.jmp | cmpr;
        e.dest  = t.jmp ? (((t.upc ? t.pc : r1) + t.imm) & 32'hFFFF_FFFE) : t.pc + t.imm;
        e.wid = t.wid; e.rd = t.rd; e.wb = t.wb; e.pc = t.pc;
        sb.push_back(e);
        first = 0;
      end
    end
  endfunction

  // monitor: sample at negedge, away from the active edge
  pkt_t br_exp, e;
  bit stalled = 0;
  logic [63:0] h_data;
  logic [4:0]  h_meta;
  always @(negedge clk) begin
    if (!reset) begin
      br_due  = 0;
      stalled = 0;
    end else begin
      chk("br_vld", branch_valid, br_due);
      if (br_due) begin
        chk("br_taken", branch_taken, br_exp.taken);
        chk("br_dest", branch_dest, br_exp.dest);
        chk("br_wid", branch_wid, br_exp.wid);
      end
      br_due = 0;
      if (stalled && out_valid) begin
        chk("stall_data", out_data, h_data);
        chk("stall_meta", {out_tmask, out_pid, out_sop, out_eop}, h_meta);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("sb_empty", 1, 0);
        else begin
          logic [63:0] m;
          e = sb.pop_front();
          m = {{32{e.tmask[1]}}, {32{e.tmask[0]}}};
          chk("data", out_data & m, e.data & m);
          chk("tmask", out_tmask, e.tmask);
          chk("pid", out_pid, e.pid);
          chk("sop", out_sop, e.sop);
          chk("eop", out_eop, e.eop);
          chk("tags", {out_wid, out_rd, out_wb}, {e.wid, e.rd, e.wb});
          chk("pc", out_PC, e.pc);
          if (e.sop) gap = cyc - last_eop_cyc;
          if (e.eop) begin
            last_eop_cyc = cyc;
            br_due = e.br;
            br_exp = e;
          end
        end
      end
      stalled = out_valid && !out_ready;
      h_data  = out_data;
      h_meta  = {out_tmask, out_pid, out_sop, out_eop};
    end
  end

  // called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input ins_t t);
    bit ok = 0;
    int w = 0;
    in_op = t.op; in_is_jmp = t.jmp; in_use_PC = t.upc; in_use_imm = t.uimm;
    in_wid = t.wid; in_rd = t.rd; in_wb = t.wb; in_tmask = t.tmask; in_tid = t.tid;
    in_PC = t.pc; in_imm = t.imm; in_rs1 = t.rs1; in_rs2 = t.rs2;
    in_valid = 1;
    while (!ok && w < 200) begin
      @(negedge clk);
      if (in_ready) begin
        push_exp(t);
        ok = 1;
      end
      @(posedge clk); #1;
      w++;
    end
    in_valid = 0;
    if (!ok) chk("accept_to", 0, 1);
    else     chk("lat1", out_valid, 1);
    // scramble inputs: the captured instruction must not follow them
    in_rs1 = {$urandom, $urandom, $urandom, $urandom};
    in_rs2 = {$urandom, $urandom, $urandom, $urandom};
    in_op = 4'($urandom); in_tmask = 4'($urandom); in_PC = $urandom; in_imm = $urandom;
    in_tid = 2'($urandom); in_is_jmp = 1'($urandom);
  endtask

  task automatic drain;
    int w = 0;
    while ((sb.size() != 0 || br_due) && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 200) chk("drain_to", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  function automatic ins_t mk(input logic [3:0] op);
    ins_t t;
    t = '0;
    t.op = op; t.tmask = 4'hF;
    t.wid = 2'($urandom); t.rd = 5'($urandom); t.wb = 1'($urandom);
    t.pc = $urandom & 32'hFFFF_FFFC;
    return t;
  endfunction

  ins_t t, t2;
  initial begin
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_br_valid", branch_valid, 0);
    chk("rst_br_taken", branch_taken, 0);
    chk("rst_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1;
    #1 chk("in_ready_up", in_ready, 1);

    t = mk(0);
    t.rs1 = {32'd4, 32'd3, 32'd2, 32'd1};
    t.rs2 = {32'd40, 32'd30, 32'd20, 32'd10};
    send(t); drain;
    t.tmask = 4'b1100; send(t); drain;
    t.tmask = 4'b0000; send(t); drain;

    t = mk(9); t.rs1 = {4{32'h8000_0000}}; t.imm = 32'd4; t.uimm = 1; send(t); drain;
    t = mk(3); t.rs1 = {4{32'd1}}; t.rs2 = {4{32'hFFFF_FFFF}}; send(t); drain;
    t.op = 2; send(t); drain;

    t = mk(12); t.tid = 3; t.rs1[3] = -32'sd5; t.rs2[3] = 32'd2;
    t.pc = 32'h1000; t.imm = 32'h40; t.tmask = 4'b1010;
    send(t); drain;
    t.op = 15; send(t); drain;

    t = mk(0); t.jmp = 1; t.rs1[0] = 32'h2003; t.imm = 32'd4; t.tid = 0; t.pc = 32'h3000;
    send(t);
    @(posedge clk); #1 out_ready = 0;
    repeat (3) begin @(posedge clk); #1; end
    out_ready = 1;
    drain;

    t = mk(0); t.rs1 = {$urandom, $urandom, $urandom, $urandom}; t.rs2 = {4{32'd7}};
    t2 = mk(1); t2.rs1 = {4{32'd100}}; t2.rs2 = {32'd1, 32'd2, 32'd3, 32'd4};
    send(t); send(t2); drain;
    chk("b2b_gap", gap, 1);

    repeat (24) begin
      t = mk(4'($urandom));
      t.jmp = ($urandom_range(0, 3) == 0); t.upc = 1'($urandom); t.uimm = 1'($urandom);
      t.tmask = 4'($urandom); t.tid = 2'($urandom); t.imm = $urandom;
      t.rs1 = {$urandom, $urandom, $urandom, $urandom};
      t.rs2 = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 1) == 0) t.rs2[t.tid] = t.rs1[t.tid];
      send(t);
    end
    drain;

    out_ready = 0;
    t = mk(12); t.rs1 = {4{-32'sd1}}; t.rs2 = {4{32'd1}}; t.tid = 1;
    send(t);
    @(posedge clk); #1 reset = 0;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_br", branch_valid, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1; out_ready = 1;
    repeat (5) @(posedge clk);
    #1 chk("rst_idle", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
